// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / HI/LO sequencing controller.
package pipe_ctrl_pkg;

    // HI/LO unit sequencing states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } hilo_state_e;

    // Architectural zero register; a load targeting it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default HI/LO unit occupancy per multiply (legal 2..15).
    localparam int MUL_CYCLES_DEF = 4;

    // Width of the multiply countdown (enough for MUL_CYCLES up to 15).
    localparam int MUL_CNT_W = 4;

    // True when a source operand is actually read and names the given destination.
    function automatic logic src_match(
        input logic       uses,
        input logic [4:0] src,
        input logic [4:0] dst
    );
        return uses & (src == dst);
    endfunction

endpackage

// File: rtl/hilo_seq.sv
// HI/LO unit sequencer: tracks an in-flight MULTU/MADDU and emits a one-cycle
// commit strobe when the result is written to HI/LO.
module hilo_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic we
);

    // The start cycle itself is spent in IDLE and the commit cycle in
    // MUL_DONE, so only MUL_CYCLES-2 cycles remain for MUL_BUSY.
    localparam logic [MUL_CNT_W-1:0] CNT_LOAD = MUL_CNT_W'(MUL_CYCLES - 2);

    hilo_state_e          state_r;
    hilo_state_e          state_s;
    logic [MUL_CNT_W-1:0] cnt_r;
    logic [MUL_CNT_W-1:0] cnt_s;
    logic                 busy_r;
    logic                 we_r;

    // State, countdown and decoded status flags; reset abandons any multiply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {MUL_CNT_W{1'b0}};
            busy_r  <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != IDLE);
            we_r    <= (state_s == MUL_DONE);
        end
    end

    // Next-state and countdown logic; a start outside IDLE is ignored.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    cnt_s = CNT_LOAD;
                    if (CNT_LOAD == {MUL_CNT_W{1'b0}}) begin
                        state_s = MUL_DONE;
                    end else begin
                        state_s = MUL_BUSY;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MUL_BUSY: begin
                if (cnt_r <= {{(MUL_CNT_W-1){1'b0}}, 1'b1}) begin
                    cnt_s   = {MUL_CNT_W{1'b0}};
                    state_s = MUL_DONE;
                end else begin
                    cnt_s   = cnt_r - {{(MUL_CNT_W-1){1'b0}}, 1'b1};
                    state_s = MUL_BUSY;
                end
            end
            MUL_DONE: begin
                cnt_s   = {MUL_CNT_W{1'b0}};
                state_s = IDLE;
            end
            default: begin
                cnt_s   = {MUL_CNT_W{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    assign busy = busy_r;
    assign we   = we_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// wrong-path squash on taken branches/jumps, and HI/LO dependency stalls.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_hilo,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mul_start,
    input  logic             ex_branch_taken,
    input  logic             ex_Jump,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             hilo_busy,
    output logic             hilo_we,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             hilo_busy_s;
    logic             hilo_we_s;
    logic             load_use_s;
    logic             hilo_stall_s;
    logic             redirect_s;
    logic             pc_en_s;
    logic             ifid_en_s;
    logic             ifid_flush_s;
    logic             idex_flush_s;
    logic [CNT_W-1:0] stall_cnt_r;

    // A redirect in EX does not abort a multiply: the older MULTU/MADDU is
    // architecturally committed regardless of what follows it.
    hilo_seq #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_hilo_seq (
        .clk   (clk),
        .rst   (rst),
        .start (ex_mul_start),
        .busy  (hilo_busy_s),
        .we    (hilo_we_s)
    );

    // Hazard detection terms.
    always_comb begin
        load_use_s   = ex_MemRead & (ex_rt != REG_ZERO) &
                       (src_match(id_uses_rs, id_rs, ex_rt) |
                        src_match(id_uses_rt, id_rt, ex_rt));
        hilo_stall_s = id_is_hilo & hilo_busy_s;
        redirect_s   = ex_branch_taken | ex_Jump;
    end

    // Pipeline control priority: reset, then redirect, then stall, else run.
    always_comb begin
        pc_en_s      = 1'b0;
        ifid_en_s    = 1'b0;
        ifid_flush_s = 1'b1;
        idex_flush_s = 1'b1;
        if (!rst) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (redirect_s) begin
            // ID holds a wrong-path instruction, so any stall it caused is moot.
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (load_use_s | hilo_stall_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b1;
        end else begin
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign pc_en        = pc_en_s;
    assign ifid_en      = ifid_en_s;
    assign ifid_flush   = ifid_flush_s;
    assign idex_flush   = idex_flush_s;
    assign hilo_busy    = hilo_busy_s;
    assign hilo_we      = hilo_we_s;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MUL_CYCLES=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int CNT_W      = 4;

    // Output vector order: {pc_en, ifid_en, ifid_flush, idex_flush, hilo_busy, hilo_we}
    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b000100;
    localparam logic [5:0] O_RSTV  = 6'b001100;
    localparam logic [5:0] O_REDIR = 6'b111100;
    localparam logic [5:0] O_BSTL  = 6'b000110;
    localparam logic [5:0] O_BWE   = 6'b000111;
    localparam logic [5:0] O_BRUN  = 6'b110010;
    localparam logic [5:0] O_WRUN  = 6'b110011;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       hl;
        logic       mr;
        logic [4:0] xrt;
        logic       ms;
        logic       br;
        logic       jp;
        logic [5:0] exp;
    } stim_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_hilo;
    logic             ex_MemRead;
    logic [4:0]       ex_rt;
    logic             ex_mul_start;
    logic             ex_branch_taken;
    logic             ex_Jump;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             hilo_busy;
    logic             hilo_we;
    logic [CNT_W-1:0] stall_cycles;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] sb_q[$];

    pipe_hazard_ctrl #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_is_hilo      (id_is_hilo),
        .ex_MemRead      (ex_MemRead),
        .ex_rt           (ex_rt),
        .ex_mul_start    (ex_mul_start),
        .ex_branch_taken (ex_branch_taken),
        .ex_Jump         (ex_Jump),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .hilo_busy       (hilo_busy),
        .hilo_we         (hilo_we),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A multiply start while the HI/LO unit is occupied is illegal stimulus.
    always @(negedge clk) begin
        if (rst && ex_mul_start && hilo_busy) begin
            n_bad++;
            $display("FAIL mul_start_while_busy: start=%b busy=%b (start must only occur when idle)",
                     ex_mul_start, hilo_busy);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] obs();
        return {pc_en, ifid_en, ifid_flush, idex_flush, hilo_busy, hilo_we};
    endfunction

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic hl,
                                 input logic mr, input logic [4:0] xrt, input logic ms,
                                 input logic br, input logic jp, input logic [5:0] exp);
        stim_t s;
        s = '{rs: rs, rt: rt, urs: urs, urt: urt, hl: hl, mr: mr, xrt: xrt,
              ms: ms, br: br, jp: jp, exp: exp};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_uses_rs      = s.urs;
        id_uses_rt      = s.urt;
        id_is_hilo      = s.hl;
        ex_MemRead      = s.mr;
        ex_rt           = s.xrt;
        ex_mul_start    = s.ms;
        ex_branch_taken = s.br;
        ex_Jump         = s.jp;
    endtask

    task automatic idle_in();
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
    endtask

    // Enter at posedge+1, leave at posedge+1 with the DUT freshly out of reset.
    task automatic apply_reset();
        rst = 1'b0;
        idle_in();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        rst = 1'b0;
        idle_in();
        #1;
        sb_q.push_back(O_RSTV);
        e = sb_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want %b", obs(), e);
        end
        n_cmp++;
        if (stall_cycles !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d want 0", stall_cycles);
        end
        @(posedge clk);
        sb_q.push_back(O_RSTV);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (obs() !== e || stall_cycles !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_held: got %b/%0d want %b/0", obs(), stall_cycles, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.push_back(O_RUN);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b", obs(), e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        stim_t      tab[$];
        logic [5:0] e;
        apply_reset();
        tab.push_back(mk(5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, O_STALL));
        tab.push_back(mk(5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_STALL));
        tab.push_back(mk(5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, O_RUN));
        foreach (tab[i]) begin
            apply(tab[i]);
            sb_q.push_back(tab[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL load_use[%0d]: got %b want %b", i, obs(), e);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (stall_cycles !== 4'd2) begin
            n_bad++;
            $display("FAIL load_use_count: got %0d want 2", stall_cycles);
        end
    endtask

    task automatic test_zero_load();
        logic [5:0] e;
        apply_reset();
        apply(mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
        sb_q.push_back(O_RUN);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL zero_load: got %b want %b", obs(), e);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (stall_cycles !== 4'd0) begin
            n_bad++;
            $display("FAIL zero_load_count: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_redirect();
        stim_t      tab[$];
        logic [5:0] e;
        apply_reset();
        tab.push_back(mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, O_REDIR));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_REDIR));
        tab.push_back(mk(5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, O_REDIR));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
        foreach (tab[i]) begin
            apply(tab[i]);
            sb_q.push_back(tab[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL redirect[%0d]: got %b want %b", i, obs(), e);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (stall_cycles !== 4'd0) begin
            n_bad++;
            $display("FAIL redirect_count: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_multiply();
        stim_t      tab[$];
        logic [5:0] e;
        apply_reset();
        // MULTU in EX with MFHI right behind it in ID.
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BSTL));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BSTL));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BWE));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
        foreach (tab[i]) begin
            apply(tab[i]);
            sb_q.push_back(tab[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL multiply[%0d]: got %b want %b", i, obs(), e);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (stall_cycles !== 4'd3) begin
            n_bad++;
            $display("FAIL multiply_count: got %0d want 3", stall_cycles);
        end
    endtask

    task automatic test_redirect_in_mul();
        stim_t      tab[$];
        logic [5:0] e;
        apply_reset();
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b111110));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BRUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_WRUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
        foreach (tab[i]) begin
            apply(tab[i]);
            sb_q.push_back(tab[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL redirect_in_mul[%0d]: got %b want %b", i, obs(), e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t      tab[$];
        logic [5:0] e;
        apply_reset();
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BRUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BRUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_WRUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BRUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BRUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_WRUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, O_STALL));
        tab.push_back(mk(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_STALL));
        tab.push_back(mk(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
        foreach (tab[i]) begin
            apply(tab[i]);
            sb_q.push_back(tab[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs(), e);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (stall_cycles !== 4'd2) begin
            n_bad++;
            $display("FAIL back_to_back_count: got %0d want 2", stall_cycles);
        end
    endtask

    task automatic test_reset_mid_mul();
        stim_t      tab[$];
        logic [5:0] e;
        apply_reset();
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN));
        tab.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BSTL));
        foreach (tab[i]) begin
            apply(tab[i]);
            sb_q.push_back(tab[i].exp);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reset_mid_mul_pre[%0d]: got %b want %b", i, obs(), e);
            end
            @(posedge clk);
            #1;
        end
        // Second busy cycle: one stall has already been counted.
        sb_q.push_back(O_BSTL);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (obs() !== e || stall_cycles !== 4'd1) begin
            n_bad++;
            $display("FAIL reset_mid_mul_busy: got %b/%0d want %b/1", obs(), stall_cycles, e);
        end
        #1;
        rst = 1'b0;
        #1;
        sb_q.push_back(O_RSTV);
        e = sb_q.pop_front();
        n_cmp++;
        if (obs() !== e || stall_cycles !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_mid_mul_async: got %b/%0d want %b/0", obs(), stall_cycles, e);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            sb_q.push_back(O_RSTV);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reset_mid_mul_hold[%0d]: got %b want %b", k, obs(), e);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(O_RUN);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reset_mid_mul_after[%0d]: got %b want %b", k, obs(), e);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (stall_cycles !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_mid_mul_count: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_saturation();
        logic [5:0] e;
        apply_reset();
        apply(mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, O_STALL));
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (stall_cycles !== 4'd5) begin
            n_bad++;
            $display("FAIL saturation_mid: got %0d want 5", stall_cycles);
        end
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if (stall_cycles !== 4'd15) begin
            n_bad++;
            $display("FAIL saturation_20: got %0d want 15", stall_cycles);
        end
        repeat (3) @(posedge clk);
        sb_q.push_back(O_STALL);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (obs() !== e || stall_cycles !== 4'd15) begin
            n_bad++;
            $display("FAIL saturation_hold: got %b/%0d want %b/15", obs(), stall_cycles, e);
        end
        @(posedge clk);
        #1;
        idle_in();
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        test_reset();
        test_load_use();
        test_zero_load();
        test_redirect();
        test_multiply();
        test_redirect_in_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_saturation();
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
